hazard_scoreboard: RTL

//  Decode-stage hazard and forwarding controller for the 5-stage core. Replaces the blanket MUL stall

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_scoreboard_fwd_select.sv | 34 +++
 rtl/hazard_scoreboard.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
package hazard_pkg;

    localparam int XLEN     = 32;
    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } lo_state_t;

endpackage

// File: rtl/hazard_scoreboard_fwd_select.sv
// Per-source bypass priority mux: EX > MEM > WB > RF, x0 never forwards.
// A load in EX cannot forward, so its hit falls through to older stages.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int ADDR_SIZE = 5
) (
    input  logic [ADDR_SIZE-1:0] src_i,
    input  logic [ADDR_SIZE-1:0] ex_rd_i,
    input  logic                 ex_we_i,
    input  logic                 ex_ld_i,
    input  logic [ADDR_SIZE-1:0] mem_rd_i,
    input  logic                 mem_we_i,
    input  logic [ADDR_SIZE-1:0] wb_rd_i,
    input  logic                 wb_we_i,
    output fwd_sel_t             sel_o,
    output logic                 ex_hit_o
);

    logic nz, mem_hit, wb_hit;

    // Hit detection and priority select
    always_comb begin
        nz       = (src_i != ADDR_SIZE'(REG_ZERO));
        ex_hit_o = nz && ex_we_i && (ex_rd_i == src_i);
        mem_hit  = nz && mem_we_i && (mem_rd_i == src_i);
        wb_hit   = nz && wb_we_i && (wb_rd_i == src_i);
        sel_o    = FWD_RF;
        if (ex_hit_o && !ex_ld_i) sel_o = FWD_EX;
        else if (mem_hit)         sel_o = FWD_MEM;
        else if (wb_hit)          sel_o = FWD_WB;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard/forwarding controller with a one-entry long-latency
// (MUL fixed latency, DIV done-handshake) tracker.
// Optional build macro HAZ_PERF_CNT_EN adds stall_lu_cnt/stall_lo_cnt counters.
// MUL_LAT must be >= 1 and 2**CNT_W must exceed MUL_LAT.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int ADDR_SIZE = 5,
    parameter int MUL_LAT   = 4,
    parameter int CNT_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 D_valid,
    input  logic [ADDR_SIZE-1:0] D_ra,
    input  logic [ADDR_SIZE-1:0] D_rb,
    input  logic [ADDR_SIZE-1:0] D_rd,
    input  logic                 D_we,
    input  logic                 D_mul,
    input  logic                 D_div,
    input  logic [ADDR_SIZE-1:0] EX_rd,
    input  logic                 EX_we,
    input  logic                 EX_ld,
    input  logic [ADDR_SIZE-1:0] MEM_rd,
    input  logic                 MEM_we,
    input  logic [ADDR_SIZE-1:0] WB_rd,
    input  logic                 WB_we,
    input  logic                 div_done,
    input  logic                 flush,
    output logic                 stall_D,
    output logic [1:0]           fwd_ra_sel,
    output logic [1:0]           fwd_rb_sel,
    output logic                 lo_busy,
    output logic                 lo_wb,
    output logic [ADDR_SIZE-1:0] lo_rd
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]          stall_lu_cnt,
    output logic [31:0]          stall_lo_cnt
`endif
);

    lo_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_SIZE-1:0] lo_rd_q, lo_rd_d;

    fwd_sel_t ra_sel, rb_sel;
    logic     ra_ex_hit, rb_ex_hit;
    logic     load_use, lo_conf, issue;

    fwd_select #(.ADDR_SIZE(ADDR_SIZE)) u_fwd_ra (
        .src_i(D_ra), .ex_rd_i(EX_rd), .ex_we_i(EX_we), .ex_ld_i(EX_ld),
        .mem_rd_i(MEM_rd), .mem_we_i(MEM_we), .wb_rd_i(WB_rd), .wb_we_i(WB_we),
        .sel_o(ra_sel), .ex_hit_o(ra_ex_hit)
    );

    fwd_select #(.ADDR_SIZE(ADDR_SIZE)) u_fwd_rb (
        .src_i(D_rb), .ex_rd_i(EX_rd), .ex_we_i(EX_we), .ex_ld_i(EX_ld),
        .mem_rd_i(MEM_rd), .mem_we_i(MEM_we), .wb_rd_i(WB_rd), .wb_we_i(WB_we),
        .sel_o(rb_sel), .ex_hit_o(rb_ex_hit)
    );

    assign fwd_ra_sel = ra_sel;
    assign fwd_rb_sel = rb_sel;
    assign lo_busy    = (state_q != IDLE);
    assign lo_rd      = lo_rd_q;

    // Stall decision: load-use against EX, or any conflict with the in-flight long op
    always_comb begin
        load_use = EX_ld && (ra_ex_hit || rb_ex_hit);
        lo_conf  = lo_busy && D_valid &&
                   (((lo_rd_q != ADDR_SIZE'(REG_ZERO)) &&
                     ((D_ra == lo_rd_q) || (D_rb == lo_rd_q) || (D_we && (D_rd == lo_rd_q))))
                    || D_mul || D_div);
        stall_D  = D_valid && !flush && (load_use || lo_conf);
        issue    = D_valid && !flush && !stall_D && (D_mul || D_div);
    end

    // Long-op tracker next state; lo_wb suppressed while reset is applied
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lo_rd_d = lo_rd_q;
        lo_wb   = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    lo_rd_d = D_rd;
                    if (D_div) begin
                        state_d = DIV_RUN;
                    end else begin
                        state_d = MUL_RUN;
                        cnt_d   = CNT_W'(MUL_LAT - 1);
                    end
                end
            end
            MUL_RUN: begin
                if (cnt_q == '0) begin
                    lo_wb   = !rst;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DIV_RUN: begin
                if (div_done) begin
                    lo_wb   = !rst;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tracker state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lo_rd_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lo_rd_q <= lo_rd_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_lu_cnt_q, stall_lo_cnt_q;

    // Stall-cause counters; both may step in the same cycle, wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_lu_cnt_q <= '0;
            stall_lo_cnt_q <= '0;
        end else begin
            if (stall_D && load_use) stall_lu_cnt_q <= stall_lu_cnt_q + 32'd1;
            if (stall_D && lo_conf)  stall_lo_cnt_q <= stall_lo_cnt_q + 32'd1;
        end
    end

    assign stall_lu_cnt = stall_lu_cnt_q;
    assign stall_lo_cnt = stall_lo_cnt_q;
`endif

endmodule
